// File: rtl/transmitting_device.sv
// Ten switch-gated word FIFOs loaded from a shared counter and drained round-robin onto HEX0.
// Optional macro HEX_BLANK_IDLE_EN blanks HEX0 on transmit slots that pop nothing.
module transmitting_device #(
   parameter int WORD_SIZE   = 4,
   parameter int QUEUE_COUNT = 10,
   parameter int QUEUE_DEPTH = 4,
   parameter int TX_PERIOD   = 8
) (
   input  logic                   CLOCK_50,
   input  logic [3:0]             KEY,
   input  logic [QUEUE_COUNT-1:0] SW,
   output logic [QUEUE_COUNT-1:0] LEDR,
   output logic [6:0]             HEX0
);
   localparam int PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
   localparam int IDX_W  = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1;
   localparam int SLOT_W = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;

   logic [WORD_SIZE-1:0]   r_mem   [QUEUE_COUNT][QUEUE_DEPTH];
   logic [PTR_W-1:0]       r_wrPtr [QUEUE_COUNT];
   logic [PTR_W-1:0]       r_rdPtr [QUEUE_COUNT];
   logic [CNT_W-1:0]       r_count [QUEUE_COUNT];
   logic [WORD_SIZE-1:0]   r_gen;
   logic [IDX_W-1:0]       r_rrPtr;
   logic [SLOT_W-1:0]      r_slot;
   logic                   r_keyPrev;
   logic                   r_writePulse;
   logic [6:0]             r_hex;

   logic [IDX_W-1:0]       w_scanIdx [QUEUE_COUNT];
   logic [IDX_W-1:0]       w_serveIdx;
   logic                   w_found;
   logic                   w_slotEnd;
   logic                   w_pop;
   logic [QUEUE_COUNT-1:0] w_wr;
   logic [QUEUE_COUNT-1:0] w_popQ;
   logic [WORD_SIZE-1:0]   w_headWord;
   logic                   w_unusedKeys;

   assign w_unusedKeys = ^KEY[3:2];

   function automatic logic [6:0] hexEncode(input logic [3:0] word);
      case (word)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // Scan in reverse so the lowest offset from the round-robin pointer wins.
   always_comb begin
      w_found    = 1'b0;
      w_serveIdx = r_rrPtr;
      for (int k = 0; k < QUEUE_COUNT; k++) begin
         w_scanIdx[k] = IDX_W'((int'(r_rrPtr) + k) % QUEUE_COUNT);
      end
      for (int k = QUEUE_COUNT - 1; k >= 0; k--) begin
         if (r_count[w_scanIdx[k]] != '0) begin
            w_found    = 1'b1;
            w_serveIdx = w_scanIdx[k];
         end
      end
   end

   assign w_slotEnd  = (r_slot == SLOT_W'(TX_PERIOD - 1));
   assign w_pop      = w_slotEnd & w_found;
   assign w_headWord = r_mem[w_serveIdx][r_rdPtr[w_serveIdx]];

   // Fullness is judged on the pre-pop count, so a full queue drops a write even while popping.
   always_comb begin
      w_wr   = '0;
      w_popQ = '0;
      LEDR   = '0;
      for (int i = 0; i < QUEUE_COUNT; i++) begin
         w_wr[i]   = r_writePulse & SW[i] & (r_count[i] != CNT_W'(QUEUE_DEPTH));
         w_popQ[i] = w_pop & (w_serveIdx == IDX_W'(i));
         LEDR[i]   = (r_count[i] == CNT_W'(QUEUE_DEPTH));
      end
   end

   always_ff @(posedge CLOCK_50) begin
      for (int i = 0; i < QUEUE_COUNT; i++) begin
         if (w_wr[i]) begin
            r_mem[i][r_wrPtr[i]] <= r_gen;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!KEY[0]) begin
         r_gen        <= '0;
         r_rrPtr      <= '0;
         r_slot       <= '0;
         r_keyPrev    <= 1'b0;
         r_writePulse <= 1'b0;
         r_hex        <= 7'h7F;
         for (int i = 0; i < QUEUE_COUNT; i++) begin
            r_wrPtr[i] <= '0;
            r_rdPtr[i] <= '0;
            r_count[i] <= '0;
         end
      end else begin
         r_keyPrev    <= KEY[1];
         r_writePulse <= KEY[1] & ~r_keyPrev;
         r_slot       <= w_slotEnd ? '0 : r_slot + 1'b1;
         if (r_writePulse) begin
            r_gen <= r_gen + 1'b1;
         end
         if (w_pop) begin
            r_rrPtr <= (w_serveIdx == IDX_W'(QUEUE_COUNT - 1)) ? '0 : w_serveIdx + 1'b1;
            r_hex   <= hexEncode(4'(w_headWord));
         end
`ifdef HEX_BLANK_IDLE_EN
         else if (w_slotEnd) begin
            r_hex <= 7'h7F;
         end
`endif
         for (int i = 0; i < QUEUE_COUNT; i++) begin
            if (w_wr[i]) begin
               r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
            end
            if (w_popQ[i]) begin
               r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
            end
            r_count[i] <= r_count[i] + CNT_W'(w_wr[i]) - CNT_W'(w_popQ[i]);
         end
      end
   end

   assign HEX0 = r_hex;

endmodule

// File: tb/tb_transmitting_device.sv
// Bench for transmitting_device: a table-driven run on a slow-slot instance for the full flag,
// and a cycle-level reference model with a popped-word scoreboard on a normal instance.
`timescale 1ns/1ps
module tb_transmitting_device;
   localparam int TP = 8;
   localparam int QC = 10;
   localparam int QD = 4;

   logic       clock = 1'b0;
   logic [3:0] keyA  = 4'b0000;
   logic [3:0] keyB  = 4'b0000;
   logic [9:0] swA   = '0;
   logic [9:0] swB   = '0;
   logic [9:0] ledrA;
   logic [9:0] ledrB;
   logic [6:0] hexA;
   logic [6:0] hexB;

   always #5 clock = ~clock;

   transmitting_device #(.WORD_SIZE(4), .QUEUE_COUNT(QC), .QUEUE_DEPTH(QD), .TX_PERIOD(TP)) dut (
      .CLOCK_50(clock), .KEY(keyA), .SW(swA), .LEDR(ledrA), .HEX0(hexA));

   transmitting_device #(.WORD_SIZE(4), .QUEUE_COUNT(QC), .QUEUE_DEPTH(QD), .TX_PERIOD(1000)) dutSlow (
      .CLOCK_50(clock), .KEY(keyB), .SW(swB), .LEDR(ledrB), .HEX0(hexB));

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state for the fast instance
   logic [3:0] mq [QC][$];
   logic [3:0] sb [$];
   int         mSlot    = 0;
   int         mRr      = 0;
   logic       mKeyPrev = 1'b0;
   logic       mPulse   = 1'b0;
   logic [3:0] mGen     = 4'h0;
   logic [6:0] mHex     = 7'h7F;

   typedef struct {
      logic       key0;
      logic       key1;
      logic [9:0] sw;
      int         cycles;
      logic [9:0] expLedr;
      logic [6:0] expHex;
   } vec_t;
   vec_t vecs [13];

   function automatic logic [6:0] segOf(input logic [3:0] w);
      logic [6:0] table16 [16];
      table16 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return table16[w];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelEdge(input logic key0, input logic key1, input logic [9:0] sw);
      int         sizes [QC];
      int         popIdx;
      logic [3:0] w;
      if (!key0) begin
         for (int i = 0; i < QC; i++) mq[i].delete();
         sb.delete();
         mSlot = 0; mRr = 0; mKeyPrev = 1'b0; mPulse = 1'b0; mGen = 4'h0; mHex = 7'h7F;
         return;
      end
      for (int i = 0; i < QC; i++) sizes[i] = mq[i].size();
      popIdx = -1;
      if (mSlot == TP - 1) begin
         for (int k = 0; k < QC; k++) begin
            if (popIdx < 0 && sizes[(mRr + k) % QC] > 0) popIdx = (mRr + k) % QC;
         end
         if (popIdx >= 0) begin
            w = mq[popIdx].pop_front();
            sb.push_back(w);
            mHex = segOf(w);
            mRr  = (popIdx + 1) % QC;
         end
`ifdef HEX_BLANK_IDLE_EN
         else mHex = 7'h7F;
`endif
      end
      if (mPulse) begin
         for (int i = 0; i < QC; i++) begin
            if (sw[i] && sizes[i] < QD) mq[i].push_back(mGen);
         end
         mGen++;
      end
      mSlot    = (mSlot + 1) % TP;
      mPulse   = key1 && !mKeyPrev;
      mKeyPrev = key1;
   endtask

   task automatic checkModelOutputs();
      logic [9:0] expLed;
      logic [3:0] w;
      for (int i = 0; i < QC; i++) expLed[i] = (mq[i].size() == QD);
      checkOutput("ledr", {22'd0, ledrA}, {22'd0, expLed});
      checkOutput("hex", {25'd0, hexA}, {25'd0, mHex});
      if (sb.size() > 0) begin
         w = sb.pop_front();
         checkOutput("hexPop", {25'd0, hexA}, {25'd0, segOf(w)});
      end
   endtask

   task automatic applyStimulus(input logic key0, input logic key1, input logic [9:0] sw, input int n);
      for (int c = 0; c < n; c++) begin
         keyA = {2'b00, key1, key0};
         swA  = sw;
         @(posedge clock);
         modelEdge(key0, key1, sw);
         #1;
         checkModelOutputs();
      end
   endtask

   task automatic pulses(input logic [9:0] sw, input int n);
      for (int p = 0; p < n; p++) begin
         applyStimulus(1'b1, 1'b1, sw, 2);
         applyStimulus(1'b1, 1'b0, sw, 2);
      end
   endtask

   initial begin
      int waited;
      vecs[0]  = '{1'b0, 1'b0, 10'h000, 2, 10'h000, 7'h7F};
      vecs[1]  = '{1'b1, 1'b1, 10'h001, 2, 10'h000, 7'h7F};
      vecs[2]  = '{1'b1, 1'b0, 10'h001, 2, 10'h000, 7'h7F};
      vecs[3]  = '{1'b1, 1'b1, 10'h001, 2, 10'h000, 7'h7F};
      vecs[4]  = '{1'b1, 1'b0, 10'h001, 2, 10'h000, 7'h7F};
      vecs[5]  = '{1'b1, 1'b1, 10'h001, 2, 10'h000, 7'h7F};
      vecs[6]  = '{1'b1, 1'b0, 10'h001, 2, 10'h000, 7'h7F};
      vecs[7]  = '{1'b1, 1'b1, 10'h001, 2, 10'h001, 7'h7F};
      vecs[8]  = '{1'b1, 1'b0, 10'h001, 2, 10'h001, 7'h7F};
      vecs[9]  = '{1'b1, 1'b1, 10'h001, 2, 10'h001, 7'h7F};
      vecs[10] = '{1'b1, 1'b0, 10'h001, 2, 10'h001, 7'h7F};
      vecs[11] = '{1'b1, 1'b1, 10'h002, 2, 10'h001, 7'h7F};
      vecs[12] = '{1'b1, 1'b0, 10'h002, 2, 10'h001, 7'h7F};

      // Slow-slot instance: fill queue 0 until full, then push word 5 into queue 1
      for (int v = 0; v < 13; v++) begin
         for (int c = 0; c < vecs[v].cycles; c++) begin
            keyB = {2'b00, vecs[v].key1, vecs[v].key0};
            swB  = vecs[v].sw;
            @(posedge clock);
            #1;
         end
         checkOutput($sformatf("vec%0d.ledr", v), {22'd0, ledrB}, {22'd0, vecs[v].expLedr});
         checkOutput($sformatf("vec%0d.hex", v), {25'd0, hexB}, {25'd0, vecs[v].expHex});
      end
      waited = 0;
      while (hexB === 7'h7F && waited < 1100) begin
         @(posedge clock); #1; waited++;
      end
      checkOutput("slowFirstPop", {25'd0, hexB}, 32'h40);
      checkOutput("slowLedrAfterPop", {22'd0, ledrB}, 32'h0);
      waited = 0;
      while (hexB === 7'h40 && waited < 1100) begin
         @(posedge clock); #1; waited++;
      end
      checkOutput("slowSecondPop", {25'd0, hexB}, 32'h12);

      // Fast instance against the reference model
      applyStimulus(1'b0, 1'b0, 10'h000, 2);
      checkOutput("resetLedr", {22'd0, ledrA}, 32'h0);
      checkOutput("resetHex", {25'd0, hexA}, 32'h7F);
      applyStimulus(1'b1, 1'b0, 10'h000, 40);
      checkOutput("idleHex", {25'd0, hexA}, 32'h7F);

      pulses(10'h001, 3);
      applyStimulus(1'b1, 1'b0, 10'h001, 40);
`ifdef HEX_BLANK_IDLE_EN
      checkOutput("singleTail", {25'd0, hexA}, 32'h7F);
`else
      checkOutput("singleTail", {25'd0, hexA}, 32'h24);
`endif

      pulses(10'h000, 2);
      checkOutput("disabledLedr", {22'd0, ledrA}, 32'h0);
      pulses(10'h001, 1);
      applyStimulus(1'b1, 1'b0, 10'h000, 20);

      pulses(10'h003, 1);
      applyStimulus(1'b1, 1'b0, 10'h000, 30);
      pulses(10'h001, 1);
      pulses(10'h004, 1);
      applyStimulus(1'b1, 1'b0, 10'h000, 30);

      pulses(10'h3FF, 5);
      applyStimulus(1'b0, 1'b0, 10'h3FF, 1);
      checkOutput("midResetLedr", {22'd0, ledrA}, 32'h0);
      checkOutput("midResetHex", {25'd0, hexA}, 32'h7F);
      pulses(10'h001, 1);
      applyStimulus(1'b1, 1'b0, 10'h000, 12);
      checkOutput("afterResetWord", {25'd0, hexA}, 32'h40);

      for (int r = 0; r < 200; r++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 10'($urandom), 1);
      end
      applyStimulus(1'b1, 1'b0, 10'h000, 420);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
